isa_ext_unit: RTL

Parametrised custom-instruction execution unit for the CPU's extension opcode space. It sits beside the ALU in the execute stage, accepts one extension instruction at a time over a valid/ready issue handshake, and executes it in one or more cycles. Built-in bit ops run in a single cycle; CRC runs iteratively; user-defined ops go to an external handler over a req/ack port with timeout. Results return as a single-cycle register-file writeback pulse, and errors are reported through a fault pulse.

---
 rtl/isa_ext_pkg.sv | 28 ++
 rtl/isa_ext_bitops.sv | 64 ++++++
 rtl/isa_ext_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/isa_ext_pkg.sv
// Shared definitions for the extension-opcode execution unit:
// sub-opcodes, FSM state encoding and fault codes.
package isa_ext_pkg;

  typedef enum logic [3:0] {
    OP_POPCNT   = 4'd0,
    OP_CLZ      = 4'd1,
    OP_CTZ      = 4'd2,
    OP_REV      = 4'd3,
    OP_CRC      = 4'd4,
    OP_SIMD_ADD = 4'd5,
    OP_SIMD_MUL = 4'd6,
    OP_CUST0    = 4'd7,
    OP_CUST1    = 4'd8,
    OP_CUST2    = 4'd9
  } ext_op_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_CRC   = 2'd2;
  localparam state_t ST_CWAIT = 2'd3;

  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/isa_ext_bitops.sv
// Combinational single-cycle operations: counts, bit reverse and
// lane-wise SIMD add/multiply, selected by the extension sub-opcode.
module isa_ext_bitops
  import isa_ext_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANE_W = 2
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int LANES = DATA_W / LANE_W;

  logic [DATA_W-1:0] popcnt;
  logic [DATA_W-1:0] clz;
  logic [DATA_W-1:0] ctz;
  logic [DATA_W-1:0] rev;
  logic [DATA_W-1:0] simd_add;
  logic [DATA_W-1:0] simd_mul;

  // The highest set bit is visited last for CLZ, the lowest last for CTZ.
  always_comb begin
    popcnt = '0;
    clz    = DATA_W'(DATA_W);
    ctz    = DATA_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      popcnt = popcnt + DATA_W'(a[i]);
      if (a[i]) clz = DATA_W'(DATA_W - 1 - i);
    end
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (a[i]) ctz = DATA_W'(i);
    end
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
    assign rev[gi] = a[DATA_W-1-gi];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] lane_a;
    logic [LANE_W-1:0] lane_b;
    assign lane_a = a[gi*LANE_W +: LANE_W];
    assign lane_b = b[gi*LANE_W +: LANE_W];
    assign simd_add[gi*LANE_W +: LANE_W] = lane_a + lane_b;
    assign simd_mul[gi*LANE_W +: LANE_W] = lane_a * lane_b;
  end

  always_comb begin
    result = '0;
    case (op)
      OP_POPCNT:   result = popcnt;
      OP_CLZ:      result = clz;
      OP_CTZ:      result = ctz;
      OP_REV:      result = rev;
      OP_SIMD_ADD: result = simd_add;
      OP_SIMD_MUL: result = simd_mul;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/isa_ext_unit.sv
// Extension-opcode execution unit: issue FSM, iterative CRC engine and
// the custom-handler req/ack port with timeout.
module isa_ext_unit
  import isa_ext_pkg::*;
#(
  parameter int               DATA_W       = 8,
  parameter int               LANE_W       = 2,
  parameter int               REG_AW       = 3,
  parameter logic [DATA_W-1:0] CRC_POLY    = 8'h07,
  parameter int               CUST_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        ext_op,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              cust_req,
  output logic [1:0]        cust_sel,
  output logic [DATA_W-1:0] cust_a,
  output logic [DATA_W-1:0] cust_b,
  input  logic              cust_ack,
  input  logic [DATA_W-1:0] cust_result
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam int TW = $clog2(CUST_TIMEOUT + 1);

  state_t            state_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [DATA_W-1:0] crc_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [CW-1:0]     bit_cnt_reg;
  logic [CW-1:0]     bit_cnt_next;
  logic [TW-1:0]     wait_cnt_reg;
  logic [TW-1:0]     wait_cnt_next;
  logic [DATA_W-1:0] crc_next;
  logic [DATA_W-1:0] bitops_result;
  logic              crc_fb;
  logic              accept;

  assign issue_ready = (state_reg == ST_IDLE) && rst_n && !flush;
  assign accept      = issue_valid && issue_ready;

  isa_ext_bitops #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_bitops (
    .op     (ext_op),
    .a      (op_a),
    .b      (op_b),
    .result (bitops_result)
  );

  // MSB-first CRC step: message bit XOR crc MSB decides the polynomial XOR.
  assign crc_fb        = crc_reg[DATA_W-1] ^ shift_reg[DATA_W-1];
  assign crc_next      = {crc_reg[DATA_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
  assign bit_cnt_next  = bit_cnt_reg + 1'b1;
  assign wait_cnt_next = wait_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      rd_reg       <= '0;
      crc_reg      <= '0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      fault        <= 1'b0;
      fault_code   <= '0;
      cust_req     <= 1'b0;
      cust_sel     <= '0;
      cust_a       <= '0;
      cust_b       <= '0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      if (flush) begin
        state_reg    <= ST_IDLE;
        cust_req     <= 1'b0;
        bit_cnt_reg  <= '0;
        wait_cnt_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (accept) begin
              rd_reg <= rd_addr;
              case (ext_op)
                OP_CRC: begin
                  state_reg   <= ST_CRC;
                  crc_reg     <= op_b;
                  shift_reg   <= op_a;
                  bit_cnt_reg <= '0;
                end
                OP_CUST0, OP_CUST1, OP_CUST2: begin
                  state_reg    <= ST_CWAIT;
                  cust_req     <= 1'b1;
                  // 7,8,9 -> 0,1,2 using only the low two opcode bits
                  cust_sel     <= ext_op[1:0] + 2'd1;
                  cust_a       <= op_a;
                  cust_b       <= op_b;
                  wait_cnt_reg <= '0;
                end
                OP_POPCNT, OP_CLZ, OP_CTZ, OP_REV, OP_SIMD_ADD, OP_SIMD_MUL: begin
                  // Retired on the accept edge so the unit stays IDLE and
                  // can take another op in the writeback cycle.
                  wb_valid <= 1'b1;
                  wb_addr  <= rd_addr;
                  wb_data  <= bitops_result;
                end
                default: begin
                  fault      <= 1'b1;
                  fault_code <= FAULT_ILLEGAL;
                end
              endcase
            end
          end
          ST_CRC: begin
            crc_reg     <= crc_next;
            shift_reg   <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt_reg <= bit_cnt_next;
            if (bit_cnt_next == CW'(DATA_W)) begin
              state_reg   <= ST_IDLE;
              bit_cnt_reg <= '0;
              wb_valid    <= 1'b1;
              wb_addr     <= rd_reg;
              wb_data     <= crc_next;
            end
          end
          ST_CWAIT: begin
            wait_cnt_reg <= wait_cnt_next;
            // Ack is checked first so an ack on the timeout edge still wins.
            if (cust_ack) begin
              state_reg    <= ST_IDLE;
              cust_req     <= 1'b0;
              wait_cnt_reg <= '0;
              wb_valid     <= 1'b1;
              wb_addr      <= rd_reg;
              wb_data      <= cust_result;
            end else if (wait_cnt_next == TW'(CUST_TIMEOUT)) begin
              state_reg    <= ST_IDLE;
              cust_req     <= 1'b0;
              wait_cnt_reg <= '0;
              fault        <= 1'b1;
              fault_code   <= FAULT_TIMEOUT;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
